// File: rtl/lsa_mmio_mem_if.sv
// Request/response bus between lsa_core (master) and lsa_mmio_mem (slave).
// valid/ready: a request (mem_we|mem_oe) is taken on a rising edge with mem_ready=1; mem_valid pulses once with mem_out.
interface lsa_mmio_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              mem_fetch;
    logic              mem_we;
    logic              mem_oe;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_in;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_out;
    logic              mem_valid;

    modport master (
        output mem_fetch, mem_we, mem_oe, mem_add, mem_in,
        input  mem_ready, mem_out, mem_valid
    );

    modport slave (
        input  mem_fetch, mem_we, mem_oe, mem_add, mem_in,
        output mem_ready, mem_out, mem_valid
    );
endinterface

// File: rtl/lsa_mmio_mem.sv
// Word RAM plus MMIO window (OUT registers, synchronised IN, sticky error), one-cycle read latency.
// Optional LSA_MMIO_CYCLE_COUNTER_EN adds a free-running cycle counter at IO_BASE+OUT_CHANNELS+1.
module lsa_mmio_mem #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                MEM_DEPTH    = 256,
    parameter logic [ADDR_W-1:0] IO_BASE      = 'hFF00,
    parameter int                OUT_CHANNELS = 2,
    parameter int                OUT_W        = 8,
    parameter int                IN_W         = 8,
    parameter logic [OUT_W-1:0]  OUT_RESET    = '0
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    lsa_mmio_mem_if.slave                 bus,
    input  logic [IN_W-1:0]               io_in,
    output logic [OUT_CHANNELS*OUT_W-1:0] io_out,
    output logic                          err_out,
    output logic                          o_dbg_state
);
    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_RD = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_ram [MEM_DEPTH];
    logic [OUT_W-1:0]  r_out [OUT_CHANNELS];
    logic [IN_W-1:0]   r_sync1;
    logic [IN_W-1:0]   r_sync2;
    logic [DATA_W-1:0] r_mem_out;
    logic              r_valid;
    logic              r_err;

    logic              w_idle;
    logic              w_accept;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W-1:0] w_dec_addr;
    logic [ADDR_W-1:0] w_off;
    logic              w_is_io;
    logic              w_is_ram;
    logic              w_is_out;
    logic              w_is_in;
    logic              w_is_cnt;
    logic              w_writable;
    logic              w_readable;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_fetch;

    // Fetch is only a read qualifier for the core; it changes nothing here.
    assign w_unused_fetch = bus.mem_fetch;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) r_state <= S_IDLE;
        else           r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_rd_acc) w_next_state = S_RD;
            S_RD:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_idle        = (r_state == S_IDLE);
        bus.mem_ready = w_idle;
        o_dbg_state   = r_state;
    end

    assign w_accept = w_idle && (bus.mem_we || bus.mem_oe);
    assign w_wr_acc = w_accept && bus.mem_we;
    assign w_rd_acc = w_accept && bus.mem_oe && !bus.mem_we;

    // In IDLE the decoder serves the incoming request; in RD it serves the captured read address.
    assign w_dec_addr = w_idle ? bus.mem_add : r_rd_addr;
    assign w_off      = w_dec_addr - IO_BASE;
    assign w_is_io    = (w_dec_addr >= IO_BASE);
    assign w_is_ram   = (32'(w_dec_addr) < MEM_DEPTH);
    assign w_is_out   = w_is_io && (w_off < ADDR_W'(OUT_CHANNELS));
    assign w_is_in    = w_is_io && (w_off == ADDR_W'(OUT_CHANNELS));
`ifdef LSA_MMIO_CYCLE_COUNTER_EN
    assign w_is_cnt   = w_is_io && (w_off == ADDR_W'(OUT_CHANNELS + 1));
`else
    assign w_is_cnt   = 1'b0;
`endif
    assign w_writable = w_is_ram || w_is_out || w_is_cnt;
    assign w_readable = w_is_ram || w_is_out || w_is_in || w_is_cnt;

`ifdef LSA_MMIO_CYCLE_COUNTER_EN
    logic [DATA_W-1:0] r_cnt;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in)                r_cnt <= '0;
        else if (w_wr_acc && w_is_cnt) r_cnt <= '0;
        else                          r_cnt <= r_cnt + 1'b1;
    end
`endif

    always_comb begin
        w_rd_data = '0;
        if (w_is_ram)     w_rd_data = r_ram[w_dec_addr[RAM_AW-1:0]];
        else if (w_is_in) w_rd_data = DATA_W'(r_sync2);
`ifdef LSA_MMIO_CYCLE_COUNTER_EN
        else if (w_is_cnt) w_rd_data = r_cnt;
`endif
        for (int n = 0; n < OUT_CHANNELS; n++) begin
            if (w_is_out && (w_off == ADDR_W'(n))) w_rd_data = DATA_W'(r_out[n]);
        end
    end

    // RAM has no reset so it maps onto block memory.
    always_ff @(posedge clock_in) begin
        if (w_wr_acc && w_is_ram) r_ram[w_dec_addr[RAM_AW-1:0]] <= bus.mem_in;
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_rd_addr <= '0;
            r_mem_out <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            for (int n = 0; n < OUT_CHANNELS; n++) r_out[n] <= OUT_RESET;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            if (w_rd_acc) r_rd_addr <= bus.mem_add;
            for (int n = 0; n < OUT_CHANNELS; n++) begin
                if (w_wr_acc && w_is_out && (w_off == ADDR_W'(n))) r_out[n] <= bus.mem_in[OUT_W-1:0];
            end
            if (r_state == S_RD) begin
                r_mem_out <= w_rd_data;
                r_valid   <= 1'b1;
                if (!w_readable) r_err <= 1'b1;
            end
            if (w_wr_acc && (bus.mem_oe || !w_writable)) r_err <= 1'b1;
        end
    end

    assign bus.mem_out   = r_mem_out;
    assign bus.mem_valid = r_valid;
    assign err_out       = r_err;

    for (genvar g = 0; g < OUT_CHANNELS; g++) begin : g_io_out
        assign io_out[g*OUT_W +: OUT_W] = r_out[g];
    end
endmodule

// File: tb/tb_lsa_mmio_mem.sv
// Directed bench for lsa_mmio_mem: vector table for single transactions plus hand sequences for corner cases.
module tb_lsa_mmio_mem;
    logic        clock_in;
    logic        reset_in;
    logic [7:0]  io_in;
    logic [15:0] io_out;
    logic        err_out;
    logic        dbg_state;
    int          n_total;
    int          n_pass;
    logic [15:0] rd;

    lsa_mmio_mem_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    lsa_mmio_mem dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .bus         (bus),
        .io_in       (io_in),
        .io_out      (io_out),
        .err_out     (err_out),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        string       name;
        logic        we;
        logic        oe;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_io;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clock_in);
        reset_in = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_in = 1'b1;
        #1;
    endtask

    // Returns at accept edge + 1ns with the request already withdrawn.
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic also_oe);
        @(negedge clock_in);
        bus.mem_we  = 1'b1;
        bus.mem_oe  = also_oe;
        bus.mem_add = addr;
        bus.mem_in  = data;
        @(posedge clock_in);
        #1;
        bus.mem_we = 1'b0;
        bus.mem_oe = 1'b0;
    endtask

    // Checks the handshake timing and returns data sampled in the valid cycle.
    task automatic bus_read(input string name, input logic [15:0] addr, output logic [15:0] data);
        @(negedge clock_in);
        bus.mem_oe  = 1'b1;
        bus.mem_add = addr;
        @(posedge clock_in);
        #1;
        bus.mem_oe = 1'b0;
        check({name, " ready_low"}, bus.mem_ready, 1'b0);
        check({name, " valid_early"}, bus.mem_valid, 1'b0);
        @(posedge clock_in);
        #1;
        check({name, " valid"}, bus.mem_valid, 1'b1);
        check({name, " ready_back"}, bus.mem_ready, 1'b1);
        data = bus.mem_out;
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        reset_in      = 1'b0;
        io_in         = 8'h00;
        bus.mem_fetch = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_oe    = 1'b0;
        bus.mem_add   = '0;
        bus.mem_in    = '0;

        vecs[0] = '{"wr_ram5",    1'b1, 1'b0, 16'h0005, 16'hBEEF, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{"rd_ram5",    1'b0, 1'b1, 16'h0005, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
        vecs[2] = '{"wr_out1",    1'b1, 1'b0, 16'hFF01, 16'h12A5, 16'h0000, 16'hA500, 1'b0};
        vecs[3] = '{"wr_out0",    1'b1, 1'b0, 16'hFF00, 16'h003C, 16'h0000, 16'hA53C, 1'b0};
        vecs[4] = '{"rd_out1",    1'b0, 1'b1, 16'hFF01, 16'h0000, 16'h00A5, 16'hA53C, 1'b0};
        vecs[5] = '{"rd_out0",    1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h003C, 16'hA53C, 1'b0};
        vecs[6] = '{"wr_ram0",    1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'hA53C, 1'b0};
        vecs[7] = '{"wr_ram255",  1'b1, 1'b0, 16'h00FF, 16'hABCD, 16'h0000, 16'hA53C, 1'b0};
        vecs[8] = '{"rd_ram0",    1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1234, 16'hA53C, 1'b0};
        vecs[9] = '{"rd_ram255",  1'b0, 1'b1, 16'h00FF, 16'h0000, 16'hABCD, 16'hA53C, 1'b0};

        // ---------------- reset defaults ----------------
        repeat (2) @(negedge clock_in);
        reset_in = 1'b1;
        #1;
        check("rst ready", bus.mem_ready, 1'b1);
        check("rst valid", bus.mem_valid, 1'b0);
        check("rst mem_out", bus.mem_out, 16'h0000);
        check("rst io_out", io_out, 16'h0000);
        check("rst err", err_out, 1'b0);
        check("rst state", dbg_state, 1'b0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].oe) begin
                bus_read(vecs[i].name, vecs[i].addr, rd);
                check({vecs[i].name, " data"}, rd, vecs[i].exp_rd);
                @(posedge clock_in);
                #1;
                check({vecs[i].name, " pulse"}, bus.mem_valid, 1'b0);
            end else begin
                bus_write(vecs[i].addr, vecs[i].wdata, 1'b0);
                check({vecs[i].name, " valid"}, bus.mem_valid, 1'b0);
                check({vecs[i].name, " ready"}, bus.mem_ready, 1'b1);
            end
            check({vecs[i].name, " io_out"}, io_out, vecs[i].exp_io);
            check({vecs[i].name, " err"}, err_out, vecs[i].exp_err);
        end

        // ---------------- request during RD is ignored ----------------
        bus_write(16'h0009, 16'h1111, 1'b0);
        @(negedge clock_in);
        bus.mem_oe  = 1'b1;
        bus.mem_add = 16'h0005;
        @(posedge clock_in);
        #1;
        bus.mem_oe  = 1'b0;
        bus.mem_we  = 1'b1;
        bus.mem_add = 16'h0009;
        bus.mem_in  = 16'h7777;
        @(posedge clock_in);
        #1;
        bus.mem_we = 1'b0;
        check("busy valid", bus.mem_valid, 1'b1);
        check("busy data", bus.mem_out, 16'hBEEF);
        bus_read("busy rd9", 16'h0009, rd);
        check("busy rd9 data", rd, 16'h1111);

        // ---------------- synchronised input, read-only IN ----------------
        @(negedge clock_in);
        io_in = 8'h5A;
        repeat (3) @(posedge clock_in);
        bus_read("in", 16'hFF02, rd);
        check("in data", rd, 16'h005A);
        check("in err", err_out, 1'b0);
        bus_write(16'hFF02, 16'h00FF, 1'b0);
        check("in wr err", err_out, 1'b1);
        check("in wr io_out", io_out, 16'hA53C);
        bus_read("in again", 16'hFF02, rd);
        check("in again data", rd, 16'h005A);

        // ---------------- reset clears registers, not RAM ----------------
        do_reset();
        check("rst2 io_out", io_out, 16'h0000);
        check("rst2 err", err_out, 1'b0);
        bus_read("rst2 ram", 16'h0005, rd);
        check("rst2 ram data", rd, 16'hBEEF);

        // ---------------- write and read together ----------------
        bus_write(16'h0007, 16'h0001, 1'b1);
        check("we_oe valid", bus.mem_valid, 1'b0);
        check("we_oe ready", bus.mem_ready, 1'b1);
        check("we_oe err", err_out, 1'b1);
        @(posedge clock_in);
        #1;
        check("we_oe no_valid", bus.mem_valid, 1'b0);
        bus_read("we_oe rd7", 16'h0007, rd);
        check("we_oe rd7 data", rd, 16'h0001);
        bus_read("unmap", 16'h8000, rd);
        check("unmap data", rd, 16'h0000);

        // ---------------- unmapped accesses set err on their own ----------------
        do_reset();
        bus_write(16'h0100, 16'h5555, 1'b0);
        check("wr unmap err", err_out, 1'b1);
        do_reset();
        bus_read("rd unmap", 16'h8000, rd);
        check("rd unmap data", rd, 16'h0000);
        check("rd unmap err", err_out, 1'b1);
        do_reset();

        // ---------------- cycle counter window ----------------
`ifdef LSA_MMIO_CYCLE_COUNTER_EN
        begin
            logic [15:0] v1;
            bus_read("cnt a", 16'hFF03, v1);
            repeat (8) @(posedge clock_in);
            bus_read("cnt b", 16'hFF03, rd);
            check("cnt delta", rd - v1, 16'd10);
            bus_write(16'hFF03, 16'h0000, 1'b0);
            @(posedge clock_in);
            bus_read("cnt clr", 16'hFF03, rd);
            check("cnt clr small", (rd <= 16'd2), 1'b1);
            check("cnt err", err_out, 1'b0);
        end
`else
        bus_read("cnt off", 16'hFF03, rd);
        check("cnt off data", rd, 16'h0000);
        check("cnt off err", err_out, 1'b1);
        do_reset();
`endif

        // ---------------- reset during RD ----------------
        @(negedge clock_in);
        bus.mem_oe  = 1'b1;
        bus.mem_add = 16'h0005;
        @(posedge clock_in);
        #1;
        bus.mem_oe = 1'b0;
        check("rstrd in_rd", dbg_state, 1'b1);
        @(negedge clock_in);
        reset_in = 1'b0;
        #1;
        check("rstrd state", dbg_state, 1'b0);
        check("rstrd ready", bus.mem_ready, 1'b1);
        @(posedge clock_in);
        #1;
        check("rstrd valid", bus.mem_valid, 1'b0);
        check("rstrd mem_out", bus.mem_out, 16'h0000);
        @(negedge clock_in);
        reset_in = 1'b1;
        @(posedge clock_in);
        #1;
        check("rstrd valid2", bus.mem_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/lsa_mmio_mem.md
Name: lsa_mmio_mem

Overview:
Parametrised successor to the single-LED-port memory used beside lsa_core. It provides a word-addressed RAM plus a memory-mapped I/O window:
- OUT_CHANNELS output registers;
- one synchronised input register;
- a sticky error flag.

A ready/valid handshake means the core tolerates the one-cycle RAM read latency. It sits between lsa_core and the board pins inside the top level.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address width
MEM_DEPTH, 256, RAM words at addresses 0..MEM_DEPTH-1; must be <= IO_BASE
IO_BASE, 16'hFF00, first I/O address
OUT_CHANNELS, 2, number of output registers (1..8)
OUT_W, 8, width of each output register (<= DATA_W)
IN_W, 8, width of io_in
OUT_RESET, 0, reset value of every output register

Ports:
clock_in  in  1  system clock; all logic on the rising edge
reset_in  in  1  asynchronous, active-low reset
mem_fetch  in  1  instruction-fetch qualifier; decoded like a read, no other effect
mem_we  in  1  write request
mem_oe  in  1  read request
mem_add  in  ADDR_W  word address
mem_in  in  DATA_W  write data
mem_ready  out  1  high when a new request is accepted this cycle
mem_out  out  DATA_W  read data, valid when mem_valid=1
mem_valid  out  1  one-cycle pulse marking read data
io_in  in  IN_W  asynchronous board inputs
io_out  out  OUT_CHANNELS*OUT_W  output registers concatenated; channel 0 in the LSBs
err_out  out  1  sticky error flag

Behaviour:
- Reset (reset_in=0, asynchronous):
  - state=IDLE, mem_ready=1, mem_valid=0, mem_out=0, err_out=0.
  - Every io_out channel=OUT_RESET; input synchroniser flops=0.
  - RAM contents are not reset.
- Address map:
  - RAM: 0..MEM_DEPTH-1.
  - OUT[n] at IO_BASE+n, read/write; reads return the value zero-extended.
  - IN at IO_BASE+OUT_CHANNELS, read-only; returns the 2-flop-synchronised io_in, zero-extended.
  - Any other address is unmapped.
- A request is accepted on a rising edge with mem_ready=1 and (mem_we or mem_oe)=1.
- State machine: IDLE, RD.
  - IDLE, write accepted: RAM or OUT register updated that edge; stays IDLE; mem_ready stays 1; no mem_valid.
  - IDLE, read accepted: captures the address; goes to RD; mem_ready=0 for exactly one cycle.
  - RD: mem_out is loaded with the RAM word, I/O value, or 0 if unmapped, and mem_valid=1 in the cycle after the read was accepted. Returns to IDLE; mem_ready=1 again. Read latency = 1 cycle.
- Requests while mem_ready=0 are ignored, not queued. The core must hold them.
- mem_out holds its last read value between reads. mem_valid is a single-cycle pulse.
- mem_we and mem_oe both high: the write is performed, the read is dropped, err_out is set.
- Write to an unmapped or IN address: ignored, err_out set.
- Read of an unmapped address: returns 0, err_out set.
- err_out clears only on reset.
- Writes to OUT[n] take the low OUT_W bits of mem_in. Other channels are unchanged.
- Reset asserted during RD: returns to IDLE and mem_valid stays 0. No partial read is delivered.

Optional Feature:
LSA_MMIO_CYCLE_COUNTER_EN:
- When defined: a DATA_W free-running counter.
  - Reset to 0; increments every clock; wraps from all-ones to 0.
  - Readable at IO_BASE+OUT_CHANNELS+1.
  - A write there clears it to 0 on that edge; the count then resumes from 0 next cycle.
- When undefined: that address is unmapped (read returns 0 and sets err_out) and no counter logic exists.

Test Plan:
- Reset release -> mem_ready=1, mem_valid=0, mem_out=0, io_out=16'h0000, err_out=0 (defaults).
- Write 16'hBEEF to address 5, then read address 5 -> mem_valid one cycle after accept, mem_out=16'hBEEF; mem_ready low for exactly that one cycle.
- Write 16'h12A5 to IO_BASE+1 -> io_out=16'hA500; then write 16'h003C to IO_BASE -> io_out=16'hA53C; err_out stays 0.
- Drive io_in=8'h5A, wait 3 cycles, read IO_BASE+2 -> mem_out=16'h005A; a write to IO_BASE+2 leaves it unchanged and sets err_out=1.
- Assert mem_we and mem_oe together at address 7 with data 16'h0001 -> RAM[7]=1, no mem_valid, err_out=1; a later read of 16'h8000 (unmapped) returns 0.
- With LSA_MMIO_CYCLE_COUNTER_EN: read IO_BASE+3 twice, 10 cycles apart -> values differ by 10. Write to IO_BASE+3, then read 2 cycles later -> small value (<=2). Without the macro: the same read returns 0 and sets err_out.
